// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/sequence stage: opcode values and FSM state encoding.
package fetch_sequencer_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
    localparam logic [OP_W-1:0] OP_JMP   = 4'h2;
    localparam logic [OP_W-1:0] OP_JMPUP = 4'h3;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence stage: owns the PC, fetches words, strobes the IR and
// accumulator enables, and resolves ADD/JMP/JMPUP/HALT before the next fetch.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int bits   = 16,
    parameter int ADDR_W = 12
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic [bits-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [bits-1:0]   ir_d,
    output logic              ir_en,
    output logic              acc_en,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [bits-1:0]   ir_q, ir_d_d;
    logic              mem_req_q, mem_req_d;
    logic              ir_en_q, ir_en_d;
    logic              acc_en_q, acc_en_d;
    logic              halted_q, halted_d;
    logic [OP_W-1:0]   op_s;
    logic [ADDR_W-1:0] operand_s;

    assign op_s      = ir_q[bits-1 -: OP_W];
    assign operand_s = ir_q[ADDR_W-1:0];

    // State register.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; WAIT has no timeout and HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: begin
                if (op_s == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath and output next values; strobes are decoded from the state being entered
    // so that the registered outputs line up with LOAD / EXEC exactly.
    always_comb begin
        pc_d   = pc_q;
        ir_d_d = ir_q;
        if ((state_q == ST_WAIT) && mem_rvalid) begin
            ir_d_d = mem_rdata;
        end else begin
            ir_d_d = ir_q;
        end
        if (state_q == ST_EXEC) begin
            case (op_s)
                OP_NOP:   pc_d = pc_q + PC_ONE;
                OP_ADD:   pc_d = pc_q + PC_ONE;
                OP_JMP:   pc_d = operand_s;
                OP_JMPUP: pc_d = pc_q - operand_s;
                OP_HALT:  pc_d = pc_q;
                default:  pc_d = pc_q + PC_ONE;
            endcase
        end else begin
            pc_d = pc_q;
        end
        mem_req_d = (state_d == ST_WAIT);
        ir_en_d   = (state_d == ST_LOAD);
        acc_en_d  = (state_d == ST_EXEC) && (op_s == OP_ADD);
        halted_d  = (state_d == ST_HALT);
    end

    // Datapath and registered outputs.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= {ADDR_W{1'b0}};
            ir_q      <= {bits{1'b0}};
            mem_req_q <= 1'b0;
            ir_en_q   <= 1'b0;
            acc_en_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d_d;
            mem_req_q <= mem_req_d;
            ir_en_q   <= ir_en_d;
            acc_en_q  <= acc_en_d;
            halted_q  <= halted_d;
        end
    end

    assign mem_req = mem_req_q;
    assign pc_addr = pc_q;
    assign ir_d    = ir_q;
    assign ir_en   = ir_en_q;
    assign acc_en  = acc_en_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a table of instructions is served as a memory
// model, with a scoreboard of expected IR words checked whenever ir_en pulses.
module tb_fetch_sequencer;

    logic        c;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_req;
    logic [11:0] pc_addr;
    logic [15:0] ir_d;
    logic        ir_en;
    logic        acc_en;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] pc;
        logic [15:0] word;
        int          delay;
        logic        acc;
        logic [11:0] next_pc;
        logic        halt;
    } instr_t;

    instr_t tbl [12];
    instr_t sb_q [$];

    fetch_sequencer #(.bits(16), .ADDR_W(12)) dut (
        .c          (c),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_req    (mem_req),
        .pc_addr    (pc_addr),
        .ir_d       (ir_d),
        .ir_en      (ir_en),
        .acc_en     (acc_en),
        .halted     (halted)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ir_en must match a queued fetch; acc_en follows it by one cycle.
    initial begin
        instr_t exp_e;
        bit     pend;
        logic   pend_acc;
        pend     = 1'b0;
        pend_acc = 1'b0;
        forever begin
            @(negedge c);
            if (!rst_n) begin
                pend = 1'b0;
                sb_q.delete();
            end else if (ir_en) begin
                check("acc_en_during_ir_en", {31'd0, acc_en}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ir_en: got ir_en=1 with ir_d=%0h, expected no strobe", ir_d);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("ir_d_on_en", {16'd0, ir_d}, {16'd0, exp_e.word});
                    pend     = 1'b1;
                    pend_acc = exp_e.acc;
                end
            end else if (pend) begin
                check("acc_en_exec", {31'd0, acc_en}, {31'd0, pend_acc});
                pend = 1'b0;
            end else begin
                check("acc_en_idle", {31'd0, acc_en}, 32'd0);
            end
        end
    end

    // Serve one instruction: answer the pending request after e.delay wait cycles.
    task automatic run_instr(input instr_t e, input bit first);
        int          n;
        logic [15:0] prev;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge c);
            n++;
        end
        if (mem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got mem_req=%b after %0d cycles, expected 1", mem_req, n);
            return;
        end
        if (!first) check("cycles_to_next_req", n, 32'd1);
        check("pc_addr_fetch", {20'd0, pc_addr}, {20'd0, e.pc});
        prev = ir_d;
        for (int i = 0; i < e.delay; i++) begin
            @(negedge c);
            check("mem_req_held", {31'd0, mem_req}, 32'd1);
            check("ir_d_hold_wait", {16'd0, ir_d}, {16'd0, prev});
        end
        mem_rvalid = 1'b1;
        mem_rdata  = e.word;
        sb_q.push_back(e);
        @(negedge c);
        // A response outside WAIT must be ignored.
        mem_rdata = ~e.word;
        check("mem_req_drop", {31'd0, mem_req}, 32'd0);
        @(negedge c);
        mem_rvalid = 1'b0;
        check("ir_d_stable_exec", {16'd0, ir_d}, {16'd0, e.word});
        check("halted_exec", {31'd0, halted}, 32'd0);
        @(negedge c);
        check("pc_addr_next", {20'd0, pc_addr}, {20'd0, e.next_pc});
        check("halted_after", {31'd0, halted}, {31'd0, e.halt});
        check("mem_req_after", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        instr_t rst_e;
        tbl[0]  = '{12'h000, 16'h0000, 0, 1'b0, 12'h001, 1'b0};
        tbl[1]  = '{12'h001, 16'h1005, 0, 1'b1, 12'h002, 1'b0};
        tbl[2]  = '{12'h002, 16'h2010, 0, 1'b0, 12'h010, 1'b0};
        tbl[3]  = '{12'h010, 16'h3004, 0, 1'b0, 12'h00C, 1'b0};
        tbl[4]  = '{12'h00C, 16'h2FFF, 0, 1'b0, 12'hFFF, 1'b0};
        tbl[5]  = '{12'hFFF, 16'h0000, 0, 1'b0, 12'h000, 1'b0};
        tbl[6]  = '{12'h000, 16'h2002, 0, 1'b0, 12'h002, 1'b0};
        tbl[7]  = '{12'h002, 16'h3005, 0, 1'b0, 12'hFFD, 1'b0};
        tbl[8]  = '{12'hFFD, 16'h3000, 3, 1'b0, 12'hFFD, 1'b0};
        tbl[9]  = '{12'hFFD, 16'h7123, 1, 1'b0, 12'hFFE, 1'b0};
        tbl[10] = '{12'hFFE, 16'h1ABC, 2, 1'b1, 12'hFFF, 1'b0};
        tbl[11] = '{12'hFFF, 16'hF000, 0, 1'b0, 12'hFFF, 1'b1};

        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        repeat (2) @(negedge c);
        check("rst_pc_addr", {20'd0, pc_addr}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_ir_d", {16'd0, ir_d}, 32'd0);
        check("rst_strobes", {29'd0, ir_en, acc_en, halted}, 32'd0);
        rst_n = 1'b1;
        @(negedge c);
        check("req_after_release", {31'd0, mem_req}, 32'd1);
        check("pc_after_release", {20'd0, pc_addr}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i], (i == 0));
        end

        // HALT is terminal: requests stay low and stray responses are ignored.
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = (i == 2);
            mem_rdata  = 16'h1111;
            @(negedge c);
            check("halted_hold", {31'd0, halted}, 32'd1);
            check("halt_no_req", {31'd0, mem_req}, 32'd0);
            check("halt_pc", {20'd0, pc_addr}, 32'hFFF);
        end
        mem_rvalid = 1'b0;

        // Reset out of HALT, then reset again in the middle of a WAIT.
        rst_n = 1'b0;
        @(negedge c);
        check("rst_from_halt", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        @(negedge c);
        check("restart_req", {31'd0, mem_req}, 32'd1);
        @(negedge c);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_req", {31'd0, mem_req}, 32'd0);
        check("midwait_rst_pc", {20'd0, pc_addr}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
        @(negedge c);
        rst_n = 1'b1;
        @(negedge c);
        mem_rvalid = 1'b0;
        check("post_rst_req", {31'd0, mem_req}, 32'd1);
        check("post_rst_ir_d", {16'd0, ir_d}, 32'd0);
        rst_e = '{12'h000, 16'h1005, 0, 1'b1, 12'h001, 1'b0};
        run_instr(rst_e, 1'b1);
        @(negedge c);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
